core_bus_arbiter: RTL and testbench

//  Downstream of the per-core Avalon-MM masters. Arbitrates NCORES core master ports onto one

---
 rtl/core_bus_arbiter_if.sv | 39 +++
 rtl/core_bus_arbiter.sv | 117 +++++++++++
 tb/tb_core_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_bus_arbiter_if.sv
// rtl/core_bus_arbiter_if.sv - core-side and shared Avalon-MM bus bundle for the core arbiter
interface core_bus_arbiter_if #(
    parameter int NCORES = 4
);
    logic [NCORES*32-1:0] core_address;
    logic [NCORES-1:0]    core_read;
    logic [NCORES-1:0]    core_write;
    logic [NCORES-1:0]    core_lock;
    logic [NCORES*32-1:0] core_writedata;
    logic [NCORES*4-1:0]  core_byteenable;
    logic [NCORES*32-1:0] core_readdata;
    logic [NCORES-1:0]    core_waitrequest;
    logic [NCORES*2-1:0]  core_response;
    logic [31:0]          avl_address;
    logic                 avl_read;
    logic                 avl_write;
    logic                 avl_lock;
    logic [31:0]          avl_writedata;
    logic [3:0]           avl_byteenable;
    logic [31:0]          avl_readdata;
    logic                 avl_waitrequest;
    logic [1:0]           avl_response;

    // Arbiter side: consumes core requests and slave replies, drives the shared master
    modport slave (
        input  core_address, core_read, core_write, core_lock, core_writedata, core_byteenable,
        input  avl_readdata, avl_waitrequest, avl_response,
        output core_readdata, core_waitrequest, core_response,
        output avl_address, avl_read, avl_write, avl_lock, avl_writedata, avl_byteenable
    );

    // Environment side: cores plus the downstream slave
    modport master (
        output core_address, core_read, core_write, core_lock, core_writedata, core_byteenable,
        output avl_readdata, avl_waitrequest, avl_response,
        input  core_readdata, core_waitrequest, core_response,
        input  avl_address, avl_read, avl_write, avl_lock, avl_writedata, avl_byteenable
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - round-robin, lock-aware arbiter of core Avalon-MM ports onto one master
module core_bus_arbiter #(
    parameter int NCORES = 4
) (
    input  logic                clk,
    input  logic                rst,
    core_bus_arbiter_if.slave   bus
);
    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t            state, state_nxt;
    logic [NCORES-1:0] grant, grant_nxt;
    logic [IW-1:0]     last, last_nxt;
    logic [NCORES-1:0] req;
    logic [IW-1:0]     gidx;
    logic [IW-1:0]     pick;
    logic              pick_valid;

    // A core is requesting when it asks for either a read or a write
    always_comb req = bus.core_read | bus.core_write;

    // Index of the one-hot grant, used to steer the shared bus
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (grant[i]) gidx = IW'(i);
        end
    end

    // First requester strictly after the last served core, wrapping around
    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= NCORES; k++) begin
            idx = (int'(last) + k) % NCORES;
            if (!pick_valid && req[idx]) begin
                pick       = IW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    // State, grant and last-served registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(NCORES - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // Next state: grant in IDLE, release on completion or when an unlocked owner goes quiet
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt       = OWNED;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                end
            end
            OWNED: begin
                if (req[gidx] && !bus.avl_waitrequest) begin
                    last_nxt = gidx;
                    if (!bus.core_lock[gidx]) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else if (!req[gidx] && !bus.core_lock[gidx]) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Bus steering: owner sees the slave directly, everyone else is stalled with zeroed returns
    always_comb begin
        int gi;
        gi                   = int'(gidx);
        bus.avl_address      = '0;
        bus.avl_read         = 1'b0;
        bus.avl_write        = 1'b0;
        bus.avl_lock         = 1'b0;
        bus.avl_writedata    = '0;
        bus.avl_byteenable   = '0;
        bus.core_waitrequest = '1;
        bus.core_readdata    = '0;
        bus.core_response    = '0;
        if (state == OWNED) begin
            bus.avl_address              = bus.core_address[gi*32 +: 32];
            bus.avl_read                 = bus.core_read[gi] & ~bus.core_write[gi];
            bus.avl_write                = bus.core_write[gi];
            bus.avl_lock                 = bus.core_lock[gi];
            bus.avl_writedata            = bus.core_writedata[gi*32 +: 32];
            bus.avl_byteenable           = bus.core_byteenable[gi*4 +: 4];
            bus.core_waitrequest[gi]     = bus.avl_waitrequest;
            bus.core_readdata[gi*32 +: 32] = bus.avl_readdata;
            bus.core_response[gi*2 +: 2] = bus.avl_response;
        end
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb/tb_core_bus_arbiter.sv - self-checking bench for core_bus_arbiter
module tb_core_bus_arbiter;
    localparam int N = 4;

    logic clk;
    logic rst;

    core_bus_arbiter_if #(.NCORES(N)) bus ();

    core_bus_arbiter #(.NCORES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests;
    int failed;

    // Reference: who owns the bus and who was served last
    int m_owner;
    int m_last;
    int grant_log[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ownership model advanced at each clock edge from the bus rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_last  = N - 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && (bus.core_read[c] || bus.core_write[c])) begin
                    m_owner = c;
                    grant_log.push_back(c);
                end
            end
        end else begin
            logic r;
            r = bus.core_read[m_owner] | bus.core_write[m_owner];
            if (r && !bus.avl_waitrequest) begin
                m_last = m_owner;
                if (!bus.core_lock[m_owner]) m_owner = -1;
            end else if (!r && !bus.core_lock[m_owner]) begin
                m_owner = -1;
            end
        end
    end

    logic [31:0]      e_addr, e_wdata;
    logic             e_rd, e_wr, e_lk;
    logic [3:0]       e_be, e_wait;
    logic [N*32-1:0]  e_rdata;
    logic [N*2-1:0]   e_resp;

    // Every cycle: outputs must match what the current owner implies
    always @(negedge clk) begin
        e_addr = '0; e_wdata = '0; e_rd = 0; e_wr = 0; e_lk = 0; e_be = '0;
        e_wait = '1; e_rdata = '0; e_resp = '0;
        if (m_owner >= 0) begin
            e_addr  = bus.core_address[m_owner*32 +: 32];
            e_wdata = bus.core_writedata[m_owner*32 +: 32];
            e_be    = bus.core_byteenable[m_owner*4 +: 4];
            e_wr    = bus.core_write[m_owner];
            e_rd    = bus.core_read[m_owner] & ~bus.core_write[m_owner];
            e_lk    = bus.core_lock[m_owner];
            e_wait[m_owner] = bus.avl_waitrequest;
            e_rdata[m_owner*32 +: 32] = bus.avl_readdata;
            e_resp[m_owner*2 +: 2]    = bus.avl_response;
        end
        check("avl_read", bus.avl_read, e_rd);
        check("avl_write", bus.avl_write, e_wr);
        check("avl_lock", bus.avl_lock, e_lk);
        if (e_rd || e_wr) begin
            check("avl_address", bus.avl_address, e_addr);
            check("avl_byteenable", bus.avl_byteenable, e_be);
        end
        if (e_wr) check("avl_writedata", bus.avl_writedata, e_wdata);
        check("core_waitrequest", bus.core_waitrequest, e_wait);
        check("core_readdata", bus.core_readdata, e_rdata);
        check("core_response", bus.core_response, e_resp);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_address    = '0;
        bus.core_read       = '0;
        bus.core_write      = '0;
        bus.core_lock       = '0;
        bus.core_writedata  = '0;
        bus.core_byteenable = '0;
        bus.avl_readdata    = '0;
        bus.avl_waitrequest = 1'b0;
        bus.avl_response    = 2'b00;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int rr_exp[6];
        int lk_exp[2];
        tests  = 0;
        failed = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        idle_inputs();

        // Reset with every core requesting
        bus.core_read = 4'hF;
        bus.core_address = {32'h3000, 32'h2000, 32'h1000, 32'h0};
        tick();
        tick();
        @(negedge clk);
        check("reset_avl_read", bus.avl_read, 1'b0);
        check("reset_avl_write", bus.avl_write, 1'b0);
        check("reset_waitrequest", bus.core_waitrequest, 4'hF);
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();

        // Single read from core1, slave stalls two cycles
        bus.core_read[1] = 1'b1;
        bus.core_address[63:32] = 32'h0000_1000;
        bus.core_byteenable[7:4] = 4'hF;
        bus.avl_waitrequest = 1'b1;
        @(negedge clk);
        check("rd_cycle1_avl_read", bus.avl_read, 1'b0);
        tick();
        @(negedge clk);
        check("rd_cycle2_avl_read", bus.avl_read, 1'b1);
        check("rd_cycle2_address", bus.avl_address, 32'h0000_1000);
        check("rd_cycle2_wait", bus.core_waitrequest, 4'hF);
        tick();
        tick();
        bus.avl_waitrequest = 1'b0;
        bus.avl_readdata    = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rd_cycle4_data", bus.core_readdata[63:32], 32'hDEAD_BEEF);
        check("rd_cycle4_wait", bus.core_waitrequest, 4'b1101);
        check("rd_cycle4_others", {bus.core_readdata[127:64], bus.core_readdata[31:0]}, 96'h0);
        tick();
        idle_inputs();
        tick();

        // Round-robin among cores 0,2,3 with a zero-wait slave
        reset_dut();
        grant_log.delete();
        bus.core_read = 4'b1101;
        bus.core_address = {32'h30, 32'h20, 32'h10, 32'h00};
        for (int i = 0; i < 12; i++) tick();
        idle_inputs();
        rr_exp = '{0, 2, 3, 0, 2, 3};
        check("rr_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++)
            check("rr_order", (i < grant_log.size()) ? grant_log[i] : -1, rr_exp[i]);
        tick();

        // Locked ldrex/strex pair from core2 while core0 waits
        reset_dut();
        grant_log.delete();
        bus.core_read[2] = 1'b1;
        bus.core_lock[2] = 1'b1;
        bus.core_address[95:64] = 32'h0000_2000;
        tick();
        bus.core_read[0] = 1'b1;
        bus.core_address[31:0] = 32'h0000_3000;
        @(negedge clk);
        check("lk_ldrex_read", bus.avl_read, 1'b1);
        check("lk_ldrex_lock", bus.avl_lock, 1'b1);
        check("lk_ldrex_addr", bus.avl_address, 32'h0000_2000);
        tick();
        bus.core_read[2]  = 1'b0;
        bus.core_write[2] = 1'b1;
        bus.core_writedata[95:64] = 32'h0000_0001;
        @(negedge clk);
        check("lk_strex_write", bus.avl_write, 1'b1);
        check("lk_strex_lock", bus.avl_lock, 1'b1);
        tick();
        bus.core_write[2] = 1'b0;
        @(negedge clk);
        check("lk_hold_core0_wait", bus.core_waitrequest[0], 1'b1);
        check("lk_hold_lock", bus.avl_lock, 1'b1);
        tick();
        bus.core_lock[2] = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("lk_core0_addr", bus.avl_address, 32'h0000_3000);
        check("lk_core0_wait", bus.core_waitrequest[0], 1'b0);
        tick();
        idle_inputs();
        lk_exp = '{2, 0};
        check("lk_count", grant_log.size(), 2);
        for (int i = 0; i < 2; i++)
            check("lk_order", (i < grant_log.size()) ? grant_log[i] : -1, lk_exp[i]);

        // Error response on core3 write (read also high: write wins)
        bus.core_read[3]  = 1'b1;
        bus.core_write[3] = 1'b1;
        bus.core_address[127:96]   = 32'h0000_4000;
        bus.core_writedata[127:96] = 32'hCAFE_F00D;
        bus.core_byteenable[15:12] = 4'hF;
        bus.avl_response = 2'b11;
        tick();
        @(negedge clk);
        check("err_response", bus.core_response, 8'b11_00_00_00);
        check("err_write", bus.avl_write, 1'b1);
        check("err_read", bus.avl_read, 1'b0);
        check("err_wdata", bus.avl_writedata, 32'hCAFE_F00D);
        tick();
        idle_inputs();
        tick();

        // Reset while core1's read is stalled, then a clean retry
        bus.core_read[1] = 1'b1;
        bus.core_address[63:32] = 32'h0000_1000;
        bus.avl_waitrequest = 1'b1;
        tick();
        @(negedge clk);
        check("mr_before_read", bus.avl_read, 1'b1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mr_during_read", bus.avl_read, 1'b0);
        check("mr_during_wait", bus.core_waitrequest, 4'hF);
        tick();
        rst = 1'b0;
        tick();
        tick();
        bus.avl_waitrequest = 1'b0;
        bus.avl_readdata    = 32'h1234_5678;
        @(negedge clk);
        check("mr_retry_data", bus.core_readdata[63:32], 32'h1234_5678);
        check("mr_retry_wait", bus.core_waitrequest, 4'b1101);
        tick();
        idle_inputs();
        tick();

        // Mixed traffic against the model
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            bus.core_read       = 4'($urandom);
            bus.core_write      = 4'($urandom);
            for (int c = 0; c < N; c++) bus.core_lock[c] = ($urandom_range(0, 3) == 0);
            bus.core_address    = {$urandom, $urandom, $urandom, $urandom};
            bus.core_writedata  = {$urandom, $urandom, $urandom, $urandom};
            bus.core_byteenable = 16'($urandom);
            bus.avl_readdata    = $urandom;
            bus.avl_waitrequest = ($urandom_range(0, 2) == 0);
            bus.avl_response    = 2'($urandom);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
